// File: rtl/filtro_temp.sv
// Moving-average temperature filter: range-checks raw samples, averages the last N_PROM
// accepted ones and flags a sensor fault after ERR_LIM consecutive rejects.
module filtro_temp #(
  parameter int unsigned N_PROM         = 4,
  parameter int          LIM_SENSOR_MIN = -400,
  parameter int          LIM_SENSOR_MAX = 1000,
  parameter int unsigned ERR_LIM        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               muestra_valida,
  input  logic signed [10:0] muestra,
  output logic signed [10:0] temp_salida,
  output logic               temp_valida,
  output logic               ventana_llena,
  output logic               error_sensor
);

  localparam int unsigned Log = $clog2(N_PROM);
  localparam int unsigned SW  = 11 + Log;
  localparam int unsigned CW  = $clog2(N_PROM + 1);
  localparam int unsigned RW  = $clog2(ERR_LIM + 1);

  localparam logic signed [10:0] LimMin = LIM_SENSOR_MIN[10:0];
  localparam logic signed [10:0] LimMax = LIM_SENSOR_MAX[10:0];
  localparam logic [CW-1:0]      CntMax = CW'(N_PROM);
  localparam logic [RW-1:0]      RejMax = RW'(ERR_LIM);

  logic signed [10:0]   ventana_q [N_PROM];
  logic signed [10:0]   ventana_d [N_PROM];
  logic signed [SW-1:0] sum_q, sum_d;
  logic [CW-1:0]        count_q, count_d;
  logic [RW-1:0]        rej_q, rej_d;
  logic                 llena_q, llena_d;
  logic                 pend_q, pend_d;
  logic signed [10:0]   salida_q, salida_d;
  logic                 valida_q, valida_d;
  logic                 error_q, error_d;

  logic                 aceptada, rechazada;
  logic signed [10:0]   viejo;
  logic signed [SW-1:0] nuevo_ext, viejo_ext;

  always_comb begin
    aceptada  = muestra_valida && (muestra >= LimMin) && (muestra <= LimMax);
    rechazada = muestra_valida && !aceptada;
    viejo     = llena_q ? ventana_q[N_PROM-1] : 11'sd0;
    nuevo_ext = {{Log{muestra[10]}}, muestra};
    viejo_ext = {{Log{viejo[10]}}, viejo};

    ventana_d = ventana_q;
    sum_d     = sum_q;
    count_d   = count_q;
    llena_d   = llena_q;
    rej_d     = rej_q;
    pend_d    = 1'b0;

    if (aceptada) begin
      ventana_d[0] = muestra;
      for (int i = 1; i < int'(N_PROM); i++) begin
        ventana_d[i] = ventana_q[i-1];
      end
      sum_d   = sum_q + nuevo_ext - viejo_ext;
      count_d = (count_q == CntMax) ? count_q : count_q + 1'b1;
      llena_d = (count_d == CntMax);
      // Only samples that leave the window full produce an output next edge.
      pend_d  = llena_d;
      rej_d   = '0;
    end else if (rechazada) begin
      rej_d = (rej_q == RejMax) ? rej_q : rej_q + 1'b1;
    end

    error_d  = (rej_d == RejMax);
    valida_d = pend_q;
    salida_d = pend_q ? 11'(sum_q >>> Log) : salida_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_PROM); i++) begin
        ventana_q[i] <= '0;
      end
      sum_q    <= '0;
      count_q  <= '0;
      llena_q  <= 1'b0;
      rej_q    <= '0;
      pend_q   <= 1'b0;
      salida_q <= '0;
      valida_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      ventana_q <= ventana_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      llena_q   <= llena_d;
      rej_q     <= rej_d;
      pend_q    <= pend_d;
      salida_q  <= salida_d;
      valida_q  <= valida_d;
      error_q   <= error_d;
    end
  end

  assign temp_salida   = salida_q;
  assign temp_valida   = valida_q;
  assign ventana_llena = llena_q;
  assign error_sensor  = error_q;

endmodule

// File: tb/tb_filtro_temp.sv
// Directed bench for filtro_temp with hand-computed expectations (default parameters).
module tb_filtro_temp;

  logic               clk = 1'b0;
  logic               rst;
  logic               muestra_valida;
  logic signed [10:0] muestra;
  logic signed [10:0] temp_salida;
  logic               temp_valida;
  logic               ventana_llena;
  logic               error_sensor;

  int n_checks = 0;
  int n_fail   = 0;

  filtro_temp dut (
    .clk            (clk),
    .rst            (rst),
    .muestra_valida (muestra_valida),
    .muestra        (muestra),
    .temp_salida    (temp_salida),
    .temp_valida    (temp_valida),
    .ventana_llena  (ventana_llena),
    .error_sensor   (error_sensor)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_val);
    n_checks++;
    if (obs != exp_val) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int v);
    muestra_valida = 1'b1;
    muestra        = 11'(v);
    tick();
    muestra_valida = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 4; i++) strobe(v);
    tick();
    tick();
  endtask

  initial begin
    rst            = 1'b1;
    muestra_valida = 1'b0;
    muestra        = '0;
    do_reset();
    check("rst_salida", int'(temp_salida), 0);
    check("rst_valida", int'(temp_valida), 0);
    check("rst_llena", int'(ventana_llena), 0);
    check("rst_error", int'(error_sensor), 0);

    // Four back-to-back samples of 100
    strobe(100); check("s1_valida", int'(temp_valida), 0);
    strobe(100); check("s2_valida", int'(temp_valida), 0);
    strobe(100); check("s3_valida", int'(temp_valida), 0);
    check("s3_llena", int'(ventana_llena), 0);
    strobe(100); check("s4_valida", int'(temp_valida), 0);
    check("s4_llena", int'(ventana_llena), 1);
    tick();
    check("s4_out_valida", int'(temp_valida), 1);
    check("s4_out_salida", int'(temp_salida), 100);
    tick();
    check("hold_valida", int'(temp_valida), 0);
    check("hold_salida", int'(temp_salida), 100);

    // Ramp toward 200, continuous strobes
    strobe(200); check("r0_valida", int'(temp_valida), 0);
    strobe(200); check("r1_salida", int'(temp_salida), 125);
    check("r1_valida", int'(temp_valida), 1);
    strobe(200); check("r2_salida", int'(temp_salida), 150);
    strobe(200); check("r3_salida", int'(temp_salida), 175);
    check("r3_valida", int'(temp_valida), 1);
    tick();      check("r4_salida", int'(temp_salida), 200);
    tick();      check("r4_drain", int'(temp_valida), 0);

    // Negative floor: -5 >>> 2 = -2
    do_reset();
    strobe(-1); strobe(-1); strobe(-1); strobe(-2);
    tick();
    check("neg_valida", int'(temp_valida), 1);
    check("neg_salida", int'(temp_salida), -2);

    // Reject run and recovery
    do_reset();
    fill(100);
    strobe(1001); check("e1_error", int'(error_sensor), 0);
    check("e1_valida", int'(temp_valida), 0);
    strobe(1001); check("e2_error", int'(error_sensor), 0);
    strobe(1001); check("e3_error", int'(error_sensor), 1);
    check("e3_valida", int'(temp_valida), 0);
    check("e3_salida", int'(temp_salida), 100);
    tick();       check("e3_hold_error", int'(error_sensor), 1);
    strobe(500);  check("rec_error", int'(error_sensor), 0);
    check("rec_valida0", int'(temp_valida), 0);
    tick();
    check("rec_valida", int'(temp_valida), 1);
    check("rec_salida", int'(temp_salida), 200);

    // Limit boundaries
    do_reset();
    strobe(-400); check("b_min_sum", int'(dut.sum_q), -400);
    check("b_min_cnt", int'(dut.count_q), 1);
    strobe(-401); check("b_lo_sum", int'(dut.sum_q), -400);
    check("b_lo_cnt", int'(dut.count_q), 1);
    strobe(1000); check("b_max_sum", int'(dut.sum_q), 600);
    check("b_max_win0", int'(dut.ventana_q[0]), 1000);
    check("b_max_win1", int'(dut.ventana_q[1]), -400);
    strobe(1001); check("b_hi_sum", int'(dut.sum_q), 600);
    check("b_hi_cnt", int'(dut.count_q), 2);
    check("b_hi_win0", int'(dut.ventana_q[0]), 1000);
    strobe(0); strobe(0);
    tick();
    check("b_out_valida", int'(temp_valida), 1);
    check("b_out_salida", int'(temp_salida), 150);

    // Mid-fill reset with strobe in the reset cycle
    do_reset();
    strobe(100); strobe(100);
    rst = 1'b1; muestra_valida = 1'b1; muestra = 11'sd100;
    tick();
    rst = 1'b0; muestra_valida = 1'b0;
    check("mr_salida", int'(temp_salida), 0);
    check("mr_valida", int'(temp_valida), 0);
    check("mr_llena", int'(ventana_llena), 0);
    check("mr_error", int'(error_sensor), 0);
    check("mr_cnt", int'(dut.count_q), 0);
    strobe(50); strobe(50); strobe(50);
    tick(); check("mr_3_valida", int'(temp_valida), 0);
    tick(); check("mr_3_valida2", int'(temp_valida), 0);
    strobe(50);
    tick();
    check("mr_4_valida", int'(temp_valida), 1);
    check("mr_4_salida", int'(temp_salida), 50);

    // Reset drops a sample already in the pipeline
    strobe(70);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("pipe_drop_valida", int'(temp_valida), 0);
    check("pipe_drop_salida", int'(temp_salida), 0);
    tick();
    check("pipe_drop_valida2", int'(temp_valida), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
